divider_bcd_out: RTL and testbench



---
 rtl/divider_pkg.sv | 17 +
 rtl/bcd_adj3.sv | 9 +
 rtl/divider_bcd_out.sv | 145 ++++++++++++++
 tb/tb_divider_bcd_out.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants for the divider result path: default widths, FSM encoding, BCD blank code.
package divider_pkg;
    localparam int N_DEF     = 5;
    localparam int M_DEF     = 3;
    localparam int Q_DIG_DEF = 2;
    localparam int R_DIG_DEF = 1;
    localparam int DEPTH_DEF = 4;
    localparam int BCD_W     = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the next shift.
module bcd_adj3
    import divider_pkg::*;
(
    input  logic [BCD_W-1:0] nibble,
    output logic [BCD_W-1:0] adjusted
);
    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
endmodule

// File: rtl/divider_bcd_out.sv
// Buffers divider results in a FIFO and converts each to packed BCD for a valid/ready consumer.
// Build option: DIVBCD_ZERO_BLANK_EN drives leading-zero quotient digits as the blank code.
module divider_bcd_out
    import divider_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int M     = M_DEF,
    parameter int Q_DIG = Q_DIG_DEF,
    parameter int R_DIG = R_DIG_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 res_rdy,
    input  logic [N-1:0]         merchant,
    input  logic [M-1:0]         remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*Q_DIG-1:0]   q_bcd,
    output logic [4*R_DIG-1:0]   r_bcd,
    output logic                 overflow,
    output logic                 busy
);
    localparam int QW    = 4 * Q_DIG;
    localparam int RW    = 4 * R_DIG;
    localparam int EW    = N + M;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(N);

    localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [EW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [EW-1:0]    head;
    logic             pop, push_ok;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [QW-1:0]    q_scr, q_adj, q_next, q_fmt;
    logic [RW-1:0]    r_scr, r_adj, r_next;
    logic [N-1:0]     q_bin, r_bin;

    assign head    = mem[rd_ptr];
    assign pop     = (state == IDLE) && (count != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = res_rdy && ((count != FULL) || pop);
    assign busy    = (state != IDLE) || (count != '0);

    // NOTE: storage is not reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {merchant, remainder};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
            if (res_rdy && !push_ok) overflow <= 1'b1;
        end
    end

    for (genvar d = 0; d < Q_DIG; d++) begin : g_q_adj
        bcd_adj3 u_adj (.nibble(q_scr[4*d +: 4]), .adjusted(q_adj[4*d +: 4]));
    end
    for (genvar d = 0; d < R_DIG; d++) begin : g_r_adj
        bcd_adj3 u_adj (.nibble(r_scr[4*d +: 4]), .adjusted(r_adj[4*d +: 4]));
    end

    assign q_next = {q_adj[QW-2:0], q_bin[N-1]};
    assign r_next = {r_adj[RW-2:0], r_bin[N-1]};

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        q_fmt = q_next;
`ifdef DIVBCD_ZERO_BLANK_EN
        begin : blank_scan
            logic leading;
            leading = 1'b1;
            for (int d = Q_DIG - 1; d >= 1; d--) begin
                if (leading && (q_next[4*d +: 4] == 4'd0)) q_fmt[4*d +: 4] = BCD_BLANK;
                else leading = 1'b0;
            end
        end
`endif
    end

    // Scratch datapath is always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            q_scr <= '0;
            r_scr <= '0;
            q_bin <= head[EW-1:M];
            r_bin <= N'(head[M-1:0]);
        end else if (state == SHIFT) begin
            q_scr <= q_next;
            r_scr <= r_next;
            q_bin <= q_bin << 1;
            r_bin <= r_bin << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            q_bcd     <= '0;
            r_bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        q_bcd     <= q_fmt;
                        r_bcd     <= r_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_bcd_out.sv
// Self-checking bench for divider_bcd_out: directed scenarios plus randomized traffic vs a decimal-digit model.
module tb_divider_bcd_out;
    localparam int N = 5;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       reset, res_rdy, out_ready;
    logic [N-1:0] merchant;
    logic [M-1:0] remainder;
    logic       out_valid, overflow, busy;
    logic [7:0] q_bcd;
    logic [3:0] r_bcd;

    int tests = 0;
    int fails = 0;
    logic [7:0] got_q[$];
    logic [3:0] got_r[$];

    divider_bcd_out dut (
        .clk(clk), .reset(reset), .res_rdy(res_rdy), .merchant(merchant),
        .remainder(remainder), .out_valid(out_valid), .out_ready(out_ready),
        .q_bcd(q_bcd), .r_bcd(r_bcd), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by plain division.
    function automatic logic [7:0] exp_q(input int v);
        logic [3:0] tens, ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
`ifdef DIVBCD_ZERO_BLANK_EN
        if (tens == 4'd0) tens = 4'hF;
`endif
        return {tens, ones};
    endfunction

    function automatic logic [3:0] exp_r(input int v);
        return 4'(v % 10);
    endfunction

    // Gathers n handshaken results, checking that a stalled result holds steady.
    task automatic collect(input int n, input int budget, input bit rand_ready);
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] pq;
        logic [3:0] pr;
        while (got_q.size() < n && cyc < budget) begin
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || q_bcd !== pq || r_bcd !== pr) begin
                    fails++;
                    $display("FAIL hold: valid=%b q=%h r=%h, required valid=1 q=%h r=%h", out_valid, q_bcd, r_bcd, pq, pr);
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    got_q.push_back(q_bcd);
                    got_r.push_back(r_bcd);
                end
                stalled = !out_ready;
                pq = q_bcd;
                pr = r_bcd;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (got_q.size() != n) begin
            fails++;
            $display("FAIL collect_count: got %0d results, required %0d", got_q.size(), n);
        end
    endtask

    task automatic run_one(input string name, input int m, input int r);
        int lat = 0;
        out_ready = 1'b1;
        res_rdy   = 1'b1;
        merchant  = N'(m);
        remainder = M'(r);
        @(negedge clk);
        res_rdy = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_at_pop: got %b, required 1", name, busy); end
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat != 6) begin fails++; $display("FAIL %s latency: got %0d, required 6", name, lat); end
        tests++;
        if (q_bcd !== exp_q(m)) begin fails++; $display("FAIL %s q_bcd: got %h, required %h", name, q_bcd, exp_q(m)); end
        tests++;
        if (r_bcd !== exp_r(r)) begin fails++; $display("FAIL %s r_bcd: got %h, required %h", name, r_bcd, exp_r(r)); end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s after_handshake: valid=%b busy=%b, required 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; res_rdy = 1'b0; out_ready = 1'b0; merchant = '0; remainder = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
        tests++; if (q_bcd !== 8'h00) begin fails++; $display("FAIL reset q_bcd: got %h, required 00", q_bcd); end
        tests++; if (r_bcd !== 4'h0) begin fails++; $display("FAIL reset r_bcd: got %h, required 0", r_bcd); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset overflow: got %b, required 0", overflow); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b, required 0", busy); end
    endtask

    task automatic test_single();
        run_one("single", 31, 6);
    endtask

    task automatic test_zero();
        run_one("zero", 0, 0);
    endtask

    task automatic test_back_to_back();
        int ms[4] = '{4, 9, 10, 23};
        int rs[4] = '{3, 1, 0, 7};
        got_q.delete(); got_r.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    res_rdy = 1'b1; merchant = N'(ms[i]); remainder = M'(rs[i]);
                    @(negedge clk);
                end
                res_rdy = 1'b0;
            end
            collect(4, 200, 1'b0);
        join
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q(ms[i]) || got_r[i] !== exp_r(rs[i])) begin
                fails++;
                $display("FAIL burst[%0d]: got %h/%h, required %h/%h", i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, (i < got_r.size()) ? got_r[i] : 4'hx,
                         exp_q(ms[i]), exp_r(rs[i]));
            end
        end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL burst overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_overflow();
        int ms[6];
        int rs[6];
        bit seen = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ms[i] = $urandom_range(31, 0);
            rs[i] = $urandom_range(7, 0);
            res_rdy = 1'b1; merchant = N'(ms[i]); remainder = M'(rs[i]);
            @(negedge clk);
        end
        res_rdy = 1'b0;
        repeat (8) @(negedge clk);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf flag: got %b, required 1", overflow); end
        tests++;
        if (out_valid !== 1'b1 || q_bcd !== exp_q(ms[0])) begin
            fails++;
            $display("FAIL ovf stuck_first: valid=%b q=%h, required 1 %h", out_valid, q_bcd, exp_q(ms[0]));
        end
        got_q.delete(); got_r.delete();
        collect(5, 300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q(ms[i]) || got_r[i] !== exp_r(rs[i])) begin
                fails++;
                $display("FAIL ovf result[%0d]: required %h/%h", i, exp_q(ms[i]), exp_r(rs[i]));
            end
        end
        repeat (20) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        tests++; if (seen) begin fails++; $display("FAIL ovf extra_result: got a 6th result, required none"); end
        tests++; if (overflow !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL ovf sticky: overflow=%b busy=%b, required 1 0", overflow, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf clear_on_reset: got %b, required 0", overflow); end
    endtask

    task automatic test_backpressure();
        int m = $urandom_range(31, 10);
        int r = $urandom_range(7, 1);
        int lat = 0;
        out_ready = 1'b0;
        res_rdy = 1'b1; merchant = N'(m); remainder = M'(r);
        @(negedge clk);
        res_rdy = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (out_valid !== 1'b1 || q_bcd !== exp_q(m) || r_bcd !== exp_r(r)) begin
                fails++;
                $display("FAIL bp cycle%0d: valid=%b q=%h r=%h, required 1 %h %h", i + 1, out_valid, q_bcd, r_bcd, exp_q(m), exp_r(r));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp release: got valid=%b, required 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            res_rdy = 1'b1; merchant = N'($urandom_range(31, 0)); remainder = M'($urandom_range(7, 0));
            @(negedge clk);
        end
        res_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst out_valid: got %b, required 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst busy: got %b, required 0", busy); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL midrst overflow: got %b, required 0", overflow); end
        tests++; if (q_bcd !== 8'h00 || r_bcd !== 4'h0) begin
            fails++; $display("FAIL midrst outputs: got %h/%h, required 00/0", q_bcd, r_bcd);
        end
        run_one("post_reset", 19, 5);
    endtask

    task automatic test_random();
        int ms[16];
        int rs[16];
        for (int i = 0; i < 16; i++) begin
            ms[i] = $urandom_range(31, 0);
            rs[i] = $urandom_range(7, 0);
        end
        got_q.delete(); got_r.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    res_rdy = 1'b1; merchant = N'(ms[i]); remainder = M'(rs[i]);
                    @(negedge clk);
                    res_rdy = 1'b0;
                    repeat ($urandom_range(20, 14)) @(negedge clk);
                end
            end
            collect(16, 2000, 1'b1);
        join
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q(ms[i]) || got_r[i] !== exp_r(rs[i])) begin
                fails++;
                $display("FAIL random[%0d]: m=%0d r=%0d required %h/%h", i, ms[i], rs[i], exp_q(ms[i]), exp_r(rs[i]));
            end
        end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL random overflow: got %b, required 0", overflow); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_zero();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
